// File: rtl/kl_arbiter.sv
// Two-master KL bus arbiter: round-robin request grant into a one-entry output register,
// combinational response demux on dstid. Define KL_ARBITER_FIXED_PRIO_EN for fixed m0 priority.
module kl_arbiter #(
    parameter int unsigned MASTER_SEL_BIT = 4,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] m0_req_addr_i,
    input  logic              m0_req_wen_i,
    input  logic [63:0]       m0_req_wdata_i,
    input  logic [7:0]        m0_req_wmask_i,
    input  logic [2:0]        m0_req_size_i,
    input  logic [4:0]        m0_req_srcid_i,
    input  logic              m0_req_valid_i,
    output logic              m0_req_ready_o,
    input  logic [ADDR_W-1:0] m1_req_addr_i,
    input  logic              m1_req_wen_i,
    input  logic [63:0]       m1_req_wdata_i,
    input  logic [7:0]        m1_req_wmask_i,
    input  logic [2:0]        m1_req_size_i,
    input  logic [4:0]        m1_req_srcid_i,
    input  logic              m1_req_valid_i,
    output logic              m1_req_ready_o,
    output logic [ADDR_W-1:0] s_req_addr_o,
    output logic              s_req_wen_o,
    output logic [63:0]       s_req_wdata_o,
    output logic [7:0]        s_req_wmask_o,
    output logic [2:0]        s_req_size_o,
    output logic [4:0]        s_req_srcid_o,
    output logic              s_req_valid_o,
    input  logic              s_req_ready_i,
    input  logic [63:0]       s_resp_rdata_i,
    input  logic [2:0]        s_resp_size_i,
    input  logic [4:0]        s_resp_dstid_i,
    input  logic              s_resp_valid_i,
    output logic              s_resp_ready_o,
    output logic [63:0]       m0_resp_rdata_o,
    output logic [2:0]        m0_resp_size_o,
    output logic [4:0]        m0_resp_dstid_o,
    output logic              m0_resp_valid_o,
    input  logic              m0_resp_ready_i,
    output logic [63:0]       m1_resp_rdata_o,
    output logic [2:0]        m1_resp_size_o,
    output logic [4:0]        m1_resp_dstid_o,
    output logic              m1_resp_valid_o,
    input  logic              m1_resp_ready_i
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [63:0]       wdata;
        logic [7:0]        wmask;
        logic [2:0]        size;
        logic [4:0]        srcid;
    } req_t;

    req_t m0_req, m1_req, req_d, req_q;
    logic valid_d, valid_q;
    logic free, gnt0, gnt1;

    assign m0_req = {m0_req_addr_i, m0_req_wen_i, m0_req_wdata_i, m0_req_wmask_i,
                     m0_req_size_i, m0_req_srcid_i};
    assign m1_req = {m1_req_addr_i, m1_req_wen_i, m1_req_wdata_i, m1_req_wmask_i,
                     m1_req_size_i, m1_req_srcid_i};

    assign free = ~valid_q | s_req_ready_i;

`ifdef KL_ARBITER_FIXED_PRIO_EN
    assign gnt0 = m0_req_valid_i;
    assign gnt1 = m1_req_valid_i & ~m0_req_valid_i;
`else
    // last_q: index of the most recent winner; reset to 1 so m0 wins the first contest.
    logic last_d, last_q;

    assign gnt0 = m0_req_valid_i & (~m1_req_valid_i | last_q);
    assign gnt1 = m1_req_valid_i & (~m0_req_valid_i | ~last_q);

    always_comb begin
        last_d = last_q;
        if (free && gnt0) begin
            last_d = 1'b0;
        end else if (free && gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign m0_req_ready_o = free & gnt0;
    assign m1_req_ready_o = free & gnt1;

    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (free) begin
            if (gnt0) begin
                req_d   = m0_req;
                valid_d = 1'b1;
            end else if (gnt1) begin
                req_d   = m1_req;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign s_req_valid_o = valid_q;
    assign s_req_addr_o  = req_q.addr;
    assign s_req_wen_o   = req_q.wen;
    assign s_req_wdata_o = req_q.wdata;
    assign s_req_wmask_o = req_q.wmask;
    assign s_req_size_o  = req_q.size;
    assign s_req_srcid_o = req_q.srcid;

    // Response path holds no state: route valid/ready by the owning master's dstid bit.
    logic resp_sel;
    assign resp_sel = s_resp_dstid_i[MASTER_SEL_BIT];

    assign m0_resp_valid_o = s_resp_valid_i & ~resp_sel;
    assign m1_resp_valid_o = s_resp_valid_i & resp_sel;
    assign s_resp_ready_o  = resp_sel ? m1_resp_ready_i : m0_resp_ready_i;

    assign m0_resp_rdata_o = s_resp_rdata_i;
    assign m0_resp_size_o  = s_resp_size_i;
    assign m0_resp_dstid_o = s_resp_dstid_i;
    assign m1_resp_rdata_o = s_resp_rdata_i;
    assign m1_resp_size_o  = s_resp_size_i;
    assign m1_resp_dstid_o = s_resp_dstid_i;

endmodule

// File: doc/kl_arbiter.md
Name: kl_arbiter

Overview:
- Two-master to one-slave KL bus arbiter feeding the KL side of the KL-to-ML external bus bridge.
- Lets a second requester (debug/DMA master) share the external bus with the CPU core.
- Request path: round-robin arbitration into a one-entry registered output stage.
- Response path: combinational demux to the owning master by one bit of the destination ID.

Parameters:
- MASTER_SEL_BIT, 4, bit of srcid/dstid that identifies the master; master 0 issues srcid with this bit 0, master 1 with this bit 1.
- ADDR_W, 32, request address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- m0_req_addr, m1_req_addr  input  ADDR_W  master request address
- m0_req_wen, m1_req_wen  input  1  write enable
- m0_req_wdata, m1_req_wdata  input  64  write data
- m0_req_wmask, m1_req_wmask  input  8  byte write mask
- m0_req_size, m1_req_size  input  3  transfer size code
- m0_req_srcid, m1_req_srcid  input  5  source ID
- m0_req_valid, m1_req_valid  input  1  request valid
- m0_req_ready, m1_req_ready  output  1  request accepted
- s_req_addr/wen/wdata/wmask/size/srcid  output  ADDR_W/1/64/8/3/5  registered request to bridge
- s_req_valid  output  1  request valid to bridge
- s_req_ready  input  1  bridge accepts
- s_resp_rdata  input  64  response data
- s_resp_size  input  3  response size
- s_resp_dstid  input  5  response destination ID
- s_resp_valid  input  1  response valid
- s_resp_ready  output  1  response accepted
- m0_resp_rdata, m1_resp_rdata  output  64  response data (shared copy of s_resp_rdata)
- m0_resp_size, m1_resp_size  output  3  response size
- m0_resp_dstid, m1_resp_dstid  output  5  response destination ID
- m0_resp_valid, m1_resp_valid  output  1  response valid
- m0_resp_ready, m1_resp_ready  input  1  master accepts response

Behaviour:
- Clocking/reset:
  - Single clock clk; synchronous active-high reset rst.
  - On reset: s_req_valid=0, output register payload=0, last_grant=1 (master 0 wins the first contest).
- Output stage:
  - One-entry register. free = !s_req_valid | s_req_ready.
  - Bridge transfer occurs on s_req_valid & s_req_ready.
- Request grant, evaluated each cycle only when free=1:
  - Only m0 valid: grant m0.
  - Only m1 valid: grant m1.
  - Both valid: grant the master != last_grant.
  - Winner's mX_req_ready=1, loser's=0. Both ready=0 when free=0.
  - Grant is combinational; m*_req_ready never depends on the other master's ready.
- On a grant:
  - Payload (addr, wen, wdata, wmask, size, srcid unmodified) loads into the register.
  - s_req_valid=1 next cycle; last_grant <= winner.
- If free and no master is valid: s_req_valid <= 0.
- Latency: grant to s_req_valid is 1 cycle. Full throughput: back-to-back grants while s_req_ready is held high.
- Output stability: while s_req_valid=1 & s_req_ready=0, the payload holds stable and no grant is issued.
- Request beats: each handshake is one beat. Multi-beat writes from one master are not locked; the bridge must tolerate interleaving, or masters issue single-beat writes only.
- Response routing:
  - sel = s_resp_dstid[MASTER_SEL_BIT].
  - m{sel}_resp_valid = s_resp_valid; the other master's resp_valid=0.
  - s_resp_ready = m{sel}_resp_ready.
  - Purely combinational, zero latency.
  - rdata/size/dstid broadcast to both masters.
- Simultaneous events: a request grant and a response beat in the same cycle are independent.
- Reset mid-operation: the pending register entry is dropped (s_req_valid=0 the next cycle); no response state is held.

Optional Feature:
- Macro KL_ARBITER_FIXED_PRIO_EN.
- Defined: master 0 always wins when both masters are valid; last_grant is unused.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then m0 and m1 both valid every cycle with s_req_ready=1 -> grants alternate m0,m1,m0,m1; s_req_srcid alternates 0x00,0x10.
- m0 single write addr=0x8000_0000 wdata=0x1122334455667788 wmask=0xFF -> s_req_* matches exactly 1 cycle later; m0_req_ready pulsed for 1 cycle.
- s_req_ready=0 for 5 cycles with the register full -> payload stable; both m*_req_ready=0; on release, next grant the following cycle.
- Response dstid=0x10 with m1_resp_ready=0 -> m1_resp_valid=1, m0_resp_valid=0, s_resp_ready=0; raise m1_resp_ready -> s_resp_ready=1 the same cycle.
- rst asserted while s_req_valid=1 -> s_req_valid=0 the next cycle; the first grant after reset goes to m0 when both are valid.
- With KL_ARBITER_FIXED_PRIO_EN defined and both valid for 4 cycles -> 4 grants all to m0; m1 is granted only when m0_req_valid=0.
